// File: rtl/dds_phase_gen.sv
// -----------------------------------------------------------------------------
// dds_phase_gen
//
// Phase accumulator (NCO) that feeds the waveform ROM stage. It produces the
// phase sequence, the waveform select and the ROM enable for that stage.
//
// Frequency word, phase offset and waveform select arrive on a valid/ready
// configuration port:
//   - While idle, an accepted configuration becomes active immediately.
//   - While running, it is parked in a shadow register. It becomes active only
//     at a phase wrap, or on the next edge when the active word is zero. This
//     keeps waveform changes on period boundaries.
//
// Stopping is also aligned to a period boundary. When run is lowered, the
// accumulator keeps going until the next carry-out, then returns to idle.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high
//   run         level request: 1 = generate, 0 = stop at next period boundary
//   cfg_valid   configuration offered
//   cfg_ready   configuration can be accepted this cycle (combinational)
//   cfg_fword   frequency control word, ACC_W bits
//   cfg_poff    phase offset added to the output phase, PHASE_W bits
//   cfg_select  waveform select: 00 tri, 01 rev-tri, 10 square, 11 cosine
//   rom_en      enable to the ROM stage (registered)
//   select      active waveform select to the ROM stage (registered)
//   phase_out   phase to the ROM stage (registered)
//   wrap_pulse  one-cycle strobe on accumulator carry-out (registered)
// -----------------------------------------------------------------------------
module dds_phase_gen #(
    parameter int ACC_W   = 32,
    parameter int PHASE_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [ACC_W-1:0]   cfg_fword,
    input  logic [PHASE_W-1:0] cfg_poff,
    input  logic [1:0]         cfg_select,
    output logic               rom_en,
    output logic [1:0]         select,
    output logic [PHASE_W-1:0] phase_out,
    output logic               wrap_pulse
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STOP_PEND = 2'd2
    } state_t;

    state_t state;

    // Active configuration. The active select is the select output register.
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   fword;
    logic [PHASE_W-1:0] poff;

    // Configuration staged while running, waiting for a period boundary.
    logic [ACC_W-1:0]   sh_fword;
    logic [PHASE_W-1:0] sh_poff;
    logic [1:0]         sh_select;
    logic               shadow_valid;

    // Next-state helpers
    logic               cfg_fire;
    logic [ACC_W:0]     sum;
    logic               carry;
    logic               fword_zero;
    logic               boundary;
    logic               apply_shadow;
    logic               stop_now;
    logic [PHASE_W-1:0] eff_poff;
    logic [PHASE_W-1:0] run_phase;
    logic [ACC_W-1:0]   idle_fword;
    logic [PHASE_W-1:0] idle_poff;
    logic [PHASE_W-1:0] idle_phase;

    // The ready rule depends only on state, shadow occupancy and reset. While
    // idle the port is always open. While running, one staged configuration
    // at a time is accepted.
    always_comb begin
        cfg_ready = !rst && ((state == IDLE) || !shadow_valid);
    end

    // NOTE: every combinational output gets a value on every path (here by
    // straight-line assignment), so no latch is inferred; blocking '=' is
    // correct in always_comb, non-blocking '<=' is reserved for the flops.
    always_comb begin
        cfg_fire   = cfg_valid && cfg_ready;

        // The extra MSB of the sum is the carry-out, i.e. the phase wrap.
        sum        = {1'b0, acc} + {1'b0, fword};
        carry      = sum[ACC_W];
        fword_zero = (fword == '0);

        // A zero word never wraps. Treat every edge as a boundary so a pending
        // configuration cannot be stranded.
        boundary     = carry || fword_zero;
        apply_shadow = shadow_valid && boundary;

        // run has priority over the stop. Re-raising it on the boundary edge
        // simply keeps generating.
        stop_now   = (state == STOP_PEND) && !run && boundary;

        // The new offset is visible on the same edge the shadow is applied.
        // The new word only joins the following addition.
        eff_poff   = apply_shadow ? sh_poff : poff;
        run_phase  = sum[ACC_W-1 -: PHASE_W] + eff_poff;

        // From idle the accumulator starts at zero, so its first value is the
        // word itself. A configuration accepted on the start edge is used at
        // once.
        idle_fword = cfg_fire ? cfg_fword : fword;
        idle_poff  = cfg_fire ? cfg_poff  : poff;
        idle_phase = idle_fword[ACC_W-1 -: PHASE_W] + idle_poff;
    end

    // NOTE: all state is registered with non-blocking '<=' so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= '0;
            fword        <= '0;
            poff         <= '0;
            select       <= '0;
            sh_fword     <= '0;
            sh_poff      <= '0;
            sh_select    <= '0;
            shadow_valid <= 1'b0;
            rom_en       <= 1'b0;
            phase_out    <= '0;
            wrap_pulse   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wrap_pulse <= 1'b0;
                    if (cfg_fire) begin
                        fword  <= cfg_fword;
                        poff   <= cfg_poff;
                        select <= cfg_select;
                    end
                    if (run) begin
                        state     <= RUN;
                        acc       <= idle_fword;
                        phase_out <= idle_phase;
                        rom_en    <= 1'b1;
                    end else begin
                        acc       <= '0;
                        phase_out <= '0;
                        rom_en    <= 1'b0;
                    end
                end

                RUN, STOP_PEND: begin
                    wrap_pulse <= carry;

                    if (apply_shadow) begin
                        fword        <= sh_fword;
                        poff         <= sh_poff;
                        select       <= sh_select;
                        shadow_valid <= 1'b0;
                    end

                    if (stop_now) begin
                        state     <= IDLE;
                        acc       <= '0;
                        phase_out <= '0;
                        rom_en    <= 1'b0;
                        // A configuration accepted on the final edge has no
                        // later wrap to wait for, so it becomes active
                        // directly. It can only fire when the shadow was
                        // empty, so it never collides with apply_shadow.
                        if (cfg_fire) begin
                            fword  <= cfg_fword;
                            poff   <= cfg_poff;
                            select <= cfg_select;
                        end
                    end else begin
                        state     <= run ? RUN : STOP_PEND;
                        acc       <= sum[ACC_W-1:0];
                        phase_out <= run_phase;
                        rom_en    <= 1'b1;
                        // Acceptance implies the shadow was empty. A cfg that
                        // lands on a wrap edge therefore waits for the next
                        // boundary.
                        if (cfg_fire) begin
                            sh_fword     <= cfg_fword;
                            sh_poff      <= cfg_poff;
                            sh_select    <= cfg_select;
                            shadow_valid <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dds_phase_gen.sv
// -----------------------------------------------------------------------------
// tb_dds_phase_gen
//
// Self-checking bench for dds_phase_gen (ACC_W=32, PHASE_W=8).
// Inputs change on the falling edge. cfg_ready is checked 1 ns later, and the
// registered outputs 1 ns after the rising edge. The reference model tracks
// the accumulator as a plain integer and applies the NCO rules with
// arithmetic. Directed scenarios come first, followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_dds_phase_gen;

    localparam int ACC_W   = 32;
    localparam int PHASE_W = 8;
    localparam longint unsigned ACC_MOD = 64'd1 << ACC_W;
    localparam int PH_MOD  = 1 << PHASE_W;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               run = 1'b0;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [ACC_W-1:0]   cfg_fword = '0;
    logic [PHASE_W-1:0] cfg_poff = '0;
    logic [1:0]         cfg_select = '0;
    logic               rom_en;
    logic [1:0]         select;
    logic [PHASE_W-1:0] phase_out;
    logic               wrap_pulse;

    dds_phase_gen #(.ACC_W(ACC_W), .PHASE_W(PHASE_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_fword  (cfg_fword),
        .cfg_poff   (cfg_poff),
        .cfg_select (cfg_select),
        .rom_en     (rom_en),
        .select     (select),
        .phase_out  (phase_out),
        .wrap_pulse (wrap_pulse)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit              m_busy;      // generating (running or finishing a period)
    bit              m_stopping;  // run was low at the previous edge
    longint unsigned m_acc, m_fw, m_sh_fw;
    int              m_po, m_sh_po, m_sel, m_sh_sel;
    bit              m_sh;
    bit              m_rom, m_wrap;
    int              m_phase;
    bit              m_fired;

    function automatic int top_phase(input longint unsigned a);
        return int'((a >> (ACC_W - PHASE_W)) % PH_MOD);
    endfunction

    task automatic model_clear();
        m_busy = 0; m_stopping = 0; m_acc = 0; m_fw = 0; m_sh_fw = 0;
        m_po = 0; m_sh_po = 0; m_sel = 0; m_sh_sel = 0; m_sh = 0;
        m_rom = 0; m_wrap = 0; m_phase = 0;
    endtask

    task automatic model_step(input bit r, input bit ru, input bit f,
                              input longint unsigned fw, input int po, input int se);
        longint unsigned s;
        bit w, bnd;
        m_fired = f;
        if (r) begin
            model_clear();
        end else if (!m_busy) begin
            if (f) begin m_fw = fw; m_po = po; m_sel = se; end
            m_wrap = 0;
            if (ru) begin
                m_busy = 1; m_stopping = 0;
                m_acc = m_fw;
                m_phase = (top_phase(m_acc) + m_po) % PH_MOD;
                m_rom = 1;
            end else begin
                m_acc = 0; m_phase = 0; m_rom = 0;
            end
        end else begin
            s   = m_acc + m_fw;
            w   = (s >= ACC_MOD);
            bnd = w || (m_fw == 0);
            m_wrap = w;
            if (m_sh && bnd) begin
                m_fw = m_sh_fw; m_po = m_sh_po; m_sel = m_sh_sel; m_sh = 0;
            end
            if (m_stopping && !ru && bnd) begin
                m_busy = 0; m_stopping = 0;
                m_acc = 0; m_phase = 0; m_rom = 0;
                if (f) begin m_fw = fw; m_po = po; m_sel = se; end
            end else begin
                m_acc = s % ACC_MOD;
                m_phase = (top_phase(m_acc) + m_po) % PH_MOD;
                m_rom = 1;
                m_stopping = !ru;
                if (f) begin m_sh = 1; m_sh_fw = fw; m_sh_po = po; m_sh_sel = se; end
            end
        end
    endtask

    // One clock cycle: drive, check ready, clock the model, check outputs.
    task automatic drive(input bit r, input bit ru, input bit v,
                         input logic [31:0] fw, input logic [7:0] po, input logic [1:0] se);
        bit exp_ready;
        @(negedge clk);
        rst = r; run = ru; cfg_valid = v;
        cfg_fword = fw; cfg_poff = po; cfg_select = se;
        #1;
        exp_ready = !r && (!m_busy || !m_sh);
        check("cfg_ready", 32'(cfg_ready), 32'(exp_ready));
        @(posedge clk);
        model_step(r, ru, v && exp_ready, longint'(fw), int'(po), int'(se));
        #1;
        check("rom_en",     32'(rom_en),     32'(m_rom));
        check("select",     32'(select),     32'(m_sel));
        check("phase_out",  32'(phase_out),  32'(m_phase));
        check("wrap_pulse", 32'(wrap_pulse), 32'(m_wrap));
    endtask

    task automatic tick(input bit ru);
        drive(1'b0, ru, 1'b0, '0, '0, '0);
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int n;
        int prev;
        bit found;
        bit have_cfg;
        bit r_run;
        logic [31:0] r_fw;
        logic [7:0]  r_po;
        logic [1:0]  r_se;

        model_clear();

        // Reset, then idle
        drive(1, 0, 0, '0, '0, '0);
        drive(1, 0, 0, '0, '0, '0);
        tick(0);
        check("idle_rom",   32'(rom_en),    32'd0);
        check("idle_phase", 32'(phase_out), 32'd0);
        check("idle_sel",   32'(select),    32'd0);
        check("idle_ready", 32'(cfg_ready), 32'd1);

        // Basic ramp: one phase step per cycle, wrap every 256 cycles
        drive(0, 0, 1, 32'h0100_0000, 8'h00, 2'b00);
        for (int i = 1; i <= 300; i++) begin
            tick(1);
            check("ramp_phase", 32'(phase_out), 32'(i % 256));
            check("ramp_wrap",  32'(wrap_pulse), 32'((i % 256) == 0));
        end

        // Pause request then resume: the phase must stay continuous
        prev = int'(phase_out);
        for (int i = 0; i < 10; i++) tick(0);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("resume_cont", 32'(phase_out), 32'((prev + 11 + i) % 256));
        end

        // Stop at boundary: drop run at phase 0x40, expect 192 more increments
        n = 0;
        while (phase_out != 8'h40 && n < 300) begin tick(1); n++; end
        check("reach_40", 32'(phase_out), 32'h40);
        n = 0;
        do begin tick(0); n++; end while (rom_en && n < 400);
        check("stop_len",   32'(n),         32'd192);
        check("stop_phase", 32'(phase_out), 32'd0);
        check("stop_wrap",  32'(wrap_pulse), 32'd1);
        tick(0);
        check("stopped_rom", 32'(rom_en), 32'd0);

        // Offset / coarse step: 0x50,0x90,0xD0,0x10 with wrap on 0x10
        drive(0, 0, 1, 32'h4000_0000, 8'h10, 2'b00);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("coarse_phase", 32'(phase_out), 32'((8'h50 + 8'h40 * (i % 4)) % 256));
            check("coarse_wrap",  32'(wrap_pulse), 32'((i % 4) == 3));
        end

        // Glitch-free update: select changes on the wrap, step halves after
        drive(0, 1, 1, 32'h2000_0000, 8'h10, 2'b11);
        check("glitch_accept", 32'(m_fired), 32'd1);
        found = 0;
        n = 0;
        while (!found && n < 8) begin
            tick(1); n++;
            if (wrap_pulse) found = 1;
            else check("glitch_old_sel", 32'(select), 32'd0);
        end
        check("glitch_wrap_seen", 32'(found), 32'd1);
        check("glitch_new_sel",   32'(select),    32'd3);
        check("glitch_wrap_ph",   32'(phase_out), 32'h10);
        tick(1);
        check("glitch_half1", 32'(phase_out), 32'h30);
        tick(1);
        check("glitch_half2", 32'(phase_out), 32'h50);
        n = 0;
        do begin tick(0); n++; end while (rom_en && n < 20);
        check("glitch_stopped", 32'(rom_en), 32'd0);

        // Zero word: shadow applies on the next edge without a wrap
        drive(0, 0, 1, 32'h0000_0000, 8'h22, 2'b01);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("zero_hold", 32'(phase_out), 32'h22);
        end
        drive(0, 1, 1, 32'h0100_0000, 8'h00, 2'b10);
        check("zero_still", 32'(phase_out), 32'h22);
        tick(1);
        check("zero_applied_sel", 32'(select),    32'd2);
        check("zero_applied_ph",  32'(phase_out), 32'h00);
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            check("zero_ramp", 32'(phase_out), 32'(i));
        end
        // Park a configuration, then reset mid-ramp: it must be discarded
        drive(0, 1, 1, 32'h0800_0000, 8'h33, 2'b11);
        tick(1);
        drive(1, 1, 0, '0, '0, '0);
        check("rst_rom",   32'(rom_en),     32'd0);
        check("rst_phase", 32'(phase_out),  32'd0);
        check("rst_sel",   32'(select),     32'd0);
        check("rst_wrap",  32'(wrap_pulse), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("rst_discard_ph",  32'(phase_out), 32'd0);
            check("rst_discard_sel", 32'(select),    32'd0);
        end
        tick(0);
        tick(0);

        // Randomized run against the model
        have_cfg = 0;
        r_run = 0;
        r_fw = '0; r_po = '0; r_se = '0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(39) == 0) r_run = !r_run;
            if (!have_cfg && $urandom_range(3) == 0) begin
                case ($urandom_range(4))
                    0: r_fw = $urandom;
                    1: r_fw = $urandom >> 4;
                    2: r_fw = '0;
                    3: r_fw = 32'($urandom_range(7)) << 24;
                    default: r_fw = $urandom >> 1;
                endcase
                r_po = 8'($urandom);
                r_se = 2'($urandom);
                have_cfg = 1;
            end
            drive(($urandom_range(299) == 0), r_run, have_cfg, r_fw, r_po, r_se);
            if (m_fired) have_cfg = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
